// File: rtl/user_wr_sched.sv
// Round-robin write scheduler: arbitrates N_ID request streams onto one write
// channel, issues the matching mux descriptor and tracks in-flight credits.
module user_wr_sched #(
  parameter int unsigned N_ID            = 4,
  parameter int unsigned LEN_BITS        = 28,
  parameter int unsigned VADDR_BITS      = 48,
  parameter int unsigned REQ_BITS        = LEN_BITS + VADDR_BITS,
  parameter int unsigned LEN_OFFS        = 0,
  parameter int unsigned DEST_BITS       = 4,
  parameter int unsigned MAX_OUTSTANDING = 8,
  localparam int unsigned N_ID_BITS      = (N_ID > 1) ? $clog2(N_ID) : 1,
  localparam int unsigned CRED_BITS      = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                                aclk,
  input  logic                                aresetn,
  input  logic [N_ID-1:0]                     s_req_valid,
  output logic [N_ID-1:0]                     s_req_ready,
  input  logic [N_ID-1:0][REQ_BITS-1:0]       s_req_data,
  output logic                                m_req_valid,
  input  logic                                m_req_ready,
  output logic [REQ_BITS-1:0]                 m_req_data,
  output logic                                m_mux_valid,
  input  logic                                m_mux_ready,
  output logic [DEST_BITS+LEN_BITS-1:0]       m_mux_data,
  input  logic                                xfer_done,
  output logic [CRED_BITS-1:0]                outstanding,
  output logic                                err_underflow
);

  typedef enum logic {ST_IDLE, ST_ISSUE} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [N_ID_BITS-1:0]  r_last;
  logic [REQ_BITS-1:0]   r_req;
  logic [DEST_BITS-1:0]  r_dest;
  logic [LEN_BITS-1:0]   r_len;
  logic                  r_req_sent;
  logic                  r_mux_sent;
  logic [CRED_BITS-1:0]  r_outstanding;
  logic                  r_err;

  logic [N_ID_BITS-1:0]  w_winner;
  logic [N_ID_BITS-1:0]  w_idx;
  logic                  w_any;
  logic [LEN_BITS-1:0]   w_len;
  logic                  w_cred_ok;
  logic                  w_grant;
  logic                  w_req_hs;
  logic                  w_mux_hs;

  // Round-robin search starting just after the last granted index
  always_comb begin
    w_any    = 1'b0;
    w_winner = r_last;
    w_idx    = '0;
    for (int unsigned k = 1; k <= N_ID; k++) begin
      w_idx = N_ID_BITS'((32'(r_last) + k) % N_ID);
      if (!w_any && s_req_valid[w_idx]) begin
        w_any    = 1'b1;
        w_winner = w_idx;
      end
    end
  end

  assign w_len     = s_req_data[w_winner][LEN_OFFS +: LEN_BITS];
  assign w_cred_ok = (r_outstanding < CRED_BITS'(MAX_OUTSTANDING));
  assign w_grant   = (r_state == ST_IDLE) && w_any && w_cred_ok;

  // Ready is held low while in reset so no handshake can be seen upstream
  always_comb begin
    s_req_ready = '0;
    for (int unsigned i = 0; i < N_ID; i++) begin
      s_req_ready[i] = aresetn && w_grant && (w_winner == N_ID_BITS'(i));
    end
  end

  assign m_req_valid = (r_state == ST_ISSUE) && !r_req_sent;
  assign m_mux_valid = (r_state == ST_ISSUE) && !r_mux_sent;
  assign m_req_data  = r_req;
  assign m_mux_data  = {r_len, r_dest};
  assign w_req_hs    = m_req_valid && m_req_ready;
  assign w_mux_hs    = m_mux_valid && m_mux_ready;

  assign outstanding   = r_outstanding;
  assign err_underflow = r_err;

  // State register
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state logic; zero-length requests are consumed without leaving idle
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_grant && (w_len != '0)) w_state_nxt = ST_ISSUE;
      end
      ST_ISSUE: begin
        if ((r_req_sent || w_req_hs) && (r_mux_sent || w_mux_hs)) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Latched request, descriptor and per-output sent flags
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_last     <= N_ID_BITS'(N_ID - 1);
      r_req      <= '0;
      r_dest     <= '0;
      r_len      <= '0;
      r_req_sent <= 1'b0;
      r_mux_sent <= 1'b0;
    end else begin
      if (w_grant) begin
        r_req      <= s_req_data[w_winner];
        r_dest     <= DEST_BITS'(w_winner);
        r_len      <= w_len;
        r_last     <= w_winner;
        r_req_sent <= 1'b0;
        r_mux_sent <= 1'b0;
      end else begin
        if (w_req_hs) r_req_sent <= 1'b1;
        if (w_mux_hs) r_mux_sent <= 1'b1;
      end
    end
  end

  // Credit counter: descriptor issue adds, transfer completion removes
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_outstanding <= '0;
      r_err         <= 1'b0;
    end else begin
      case ({w_mux_hs, xfer_done})
        2'b10:   r_outstanding <= r_outstanding + CRED_BITS'(1);
        2'b01:   if (r_outstanding != '0) r_outstanding <= r_outstanding - CRED_BITS'(1);
        default: r_outstanding <= r_outstanding;
      endcase
      if (xfer_done && (r_outstanding == '0)) r_err <= 1'b1;
    end
  end

endmodule
